// File: rtl/alu_pkg.sv
// Shared definitions for the ALU dispatcher: opcodes, FSM states and the
// {alu_pwr_en, iso_en} power-state encoding.
package alu_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned OP_W   = 4;
  localparam int unsigned CMD_W  = 2 * DATA_W + OP_W;

  localparam logic [OP_W-1:0] OP_ADD = 4'd0;
  localparam logic [OP_W-1:0] OP_SUB = 4'd1;
  localparam logic [OP_W-1:0] OP_AND = 4'd2;
  localparam logic [OP_W-1:0] OP_OR  = 4'd3;
  localparam logic [OP_W-1:0] OP_XOR = 4'd4;
  localparam logic [OP_W-1:0] OP_SHL = 4'd5;
  localparam logic [OP_W-1:0] OP_SHR = 4'd6;
  localparam logic [OP_W-1:0] OP_SLT = 4'd7;
  localparam logic [OP_W-1:0] OP_MUL = 4'd8;
  localparam logic [OP_W-1:0] OP_DIV = 4'd9;

  typedef enum logic [2:0] {
    ST_OFF,
    ST_PWR_UP,
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_PWR_DN
  } disp_state_e;

  // Bit 1 is alu_pwr_en, bit 0 is iso_en.
  typedef enum logic [1:0] {
    PWR_OFF = 2'b01,
    PWR_ISO = 2'b11,
    PWR_ON  = 2'b10
  } pwr_state_e;

  function automatic pwr_state_e pwr_of(input disp_state_e s);
    case (s)
      ST_OFF:               return PWR_OFF;
      ST_PWR_UP, ST_PWR_DN: return PWR_ISO;
      default:              return PWR_ON;
    endcase
  endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Command queue for alu_dispatch: first-word-fall-through FIFO, power-of-2 depth.
module alu_cmd_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 36
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             empty_o,
  output logic             full_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;
  logic             do_push;
  logic             do_pop;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign data_o  = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/alu_dispatch.sv
// Power-gated dispatcher feeding a multi-cycle ALU from a command queue.
// Define ALU_DISPATCH_ERR_EN to flag divide-by-zero and undefined opcodes on rsp_err.
module alu_dispatch
  import alu_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned PWR_UP_CYC   = 4,
  parameter int unsigned IDLE_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [DATA_W-1:0] cmd_a,
  input  logic [DATA_W-1:0] cmd_b,
  input  logic [OP_W-1:0]   cmd_op,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic [OP_W-1:0]   rsp_op,
  output logic              rsp_err,
  output logic              alu_pwr_en,
  output logic              iso_en,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OP_W-1:0]   alu_opcode,
  output logic              alu_start,
  input  logic              alu_busy,
  input  logic [DATA_W-1:0] alu_result
);

  localparam int unsigned     PU_W    = $clog2(PWR_UP_CYC + 1);
  localparam int unsigned     IT_W    = $clog2(IDLE_TIMEOUT + 1);
  localparam logic [PU_W-1:0] PU_LAST = PU_W'(PWR_UP_CYC - 1);
  localparam logic [IT_W-1:0] IT_LAST = IT_W'(IDLE_TIMEOUT - 1);

  disp_state_e       state_q, state_d;
  pwr_state_e        pwr_q;
  logic [PU_W-1:0]   pwr_cnt_q, pwr_cnt_d;
  logic [IT_W-1:0]   idle_cnt_q, idle_cnt_d;
  logic              alu_start_q;
  logic [DATA_W-1:0] alu_a_q, alu_b_q;
  logic [OP_W-1:0]   alu_op_q;
  logic              rsp_valid_q;
  logic [DATA_W-1:0] rsp_data_q;
  logic [OP_W-1:0]   rsp_op_q;

  logic              push, pop, capture;
  logic              fifo_empty, fifo_full;
  logic [CMD_W-1:0]  fifo_head;

  assign cmd_ready = !fifo_full;
  assign push      = cmd_valid && !fifo_full;

  alu_cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (CMD_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .data_i  ({cmd_a, cmd_b, cmd_op}),
    .pop_i   (pop),
    .data_o  (fifo_head),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  always_comb begin
    state_d    = state_q;
    pwr_cnt_d  = '0;
    idle_cnt_d = '0;
    pop        = 1'b0;
    capture    = 1'b0;
    case (state_q)
      // A push in the same cycle wakes the ALU without waiting for the queue flop.
      ST_OFF: if (!fifo_empty || push) state_d = ST_PWR_UP;
      ST_PWR_UP: begin
        if (pwr_cnt_q == PU_LAST) state_d = ST_IDLE;
        else                      pwr_cnt_d = pwr_cnt_q + 1'b1;
      end
      ST_IDLE: begin
        if (!fifo_empty && (!rsp_valid_q || rsp_ready)) begin
          pop     = 1'b1;
          state_d = ST_ISSUE;
        end else if (push) begin
          idle_cnt_d = '0;
        end else if (fifo_empty && !rsp_valid_q) begin
          if (idle_cnt_q == IT_LAST) state_d = ST_PWR_DN;
          else                       idle_cnt_d = idle_cnt_q + 1'b1;
        end else begin
          idle_cnt_d = idle_cnt_q;
        end
      end
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT: begin
        if (!alu_busy) begin
          capture = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_PWR_DN: state_d = ST_OFF;
      default:   state_d = ST_OFF;
    endcase
  end

  // ALU-side outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_OFF;
      pwr_q       <= PWR_OFF;
      pwr_cnt_q   <= '0;
      idle_cnt_q  <= '0;
      alu_start_q <= 1'b0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_op_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_op_q    <= '0;
    end else begin
      state_q     <= state_d;
      pwr_q       <= pwr_of(state_d);
      pwr_cnt_q   <= pwr_cnt_d;
      idle_cnt_q  <= idle_cnt_d;
      alu_start_q <= pop;
      if (pop) {alu_a_q, alu_b_q, alu_op_q} <= fifo_head;
      if (capture) begin
        rsp_valid_q <= 1'b1;
        rsp_data_q  <= alu_result;
        rsp_op_q    <= alu_op_q;
      end else if (rsp_valid_q && rsp_ready) begin
        rsp_valid_q <= 1'b0;
      end
    end
  end

`ifdef ALU_DISPATCH_ERR_EN
  logic rsp_err_q;
  logic err_d;

  assign err_d = ((alu_op_q == OP_DIV) && (alu_b_q == '0)) || (alu_op_q > OP_DIV);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       rsp_err_q <= 1'b0;
    else if (capture) rsp_err_q <= err_d;
  end

  assign rsp_err = rsp_err_q;
`else
  assign rsp_err = 1'b0;
`endif

  assign {alu_pwr_en, iso_en} = pwr_q;
  assign alu_start  = alu_start_q;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_opcode = alu_op_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_data   = rsp_data_q;
  assign rsp_op     = rsp_op_q;

endmodule

// File: tb/tb_alu_dispatch.sv
// Directed self-checking bench for alu_dispatch with a behavioural ALU stand-in.
`timescale 1ns/1ps
module tb_alu_dispatch;
  import alu_pkg::*;

`ifdef ALU_DISPATCH_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0, cmd_ready;
  logic [15:0] cmd_a = '0, cmd_b = '0;
  logic [3:0]  cmd_op = '0;
  logic        rsp_valid, rsp_ready = 1'b0;
  logic [15:0] rsp_data;
  logic [3:0]  rsp_op;
  logic        rsp_err, alu_pwr_en, iso_en;
  logic [15:0] alu_a, alu_b;
  logic [3:0]  alu_opcode;
  logic        alu_start;
  logic        alu_busy = 1'b0;
  logic [15:0] alu_result = '0;

  int unsigned n_pass = 0;
  int unsigned n_total = 0;

  always #5 clk = ~clk;

  alu_dispatch dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_op(rsp_op), .rsp_err(rsp_err),
    .alu_pwr_en(alu_pwr_en), .iso_en(iso_en),
    .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
    .alu_start(alu_start), .alu_busy(alu_busy), .alu_result(alu_result)
  );

  function automatic logic [15:0] alu_fn(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      OP_SHL:  return a << b[3:0];
      OP_SHR:  return a >> b[3:0];
      OP_SLT:  return (a < b) ? 16'd1 : 16'd0;
      OP_MUL:  return a * b;
      OP_DIV:  return (b == 16'd0) ? 16'd0 : a / b;
      default: return 16'd0;
    endcase
  endfunction

  // ALU stand-in: MUL busy 5 cycles, DIV busy 9, everything else single-cycle.
  int alu_left = 0;
  always begin
    @(posedge clk);
    #1;
    if (!rst_n) begin
      alu_busy = 1'b0;
      alu_left = 0;
    end else if (alu_start) begin
      alu_result = alu_fn(alu_opcode, alu_a, alu_b);
      alu_left   = (alu_opcode == OP_MUL) ? 5 : (alu_opcode == OP_DIV) ? 9 : 0;
      alu_busy   = (alu_left > 0);
    end else if (alu_left > 0) begin
      alu_left--;
      alu_busy = (alu_left > 0);
    end
  end

  // Called at a negedge; returns at a negedge once the command has been accepted or the budget ran out.
  task automatic push_cmd(input logic [15:0] a, input logic [15:0] b, input logic [3:0] op, output bit ok);
    ok = 1'b0;
    cmd_a = a; cmd_b = b; cmd_op = op; cmd_valid = 1'b1;
    for (int t = 0; t < 20 && !ok; t++) begin
      if (cmd_ready) ok = 1'b1;
      @(negedge clk);
    end
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int budget, output bit got, output int starts);
    got = 1'b0;
    starts = 0;
    for (int t = 0; t < budget && !got; t++) begin
      if (alu_start) starts++;
      if (rsp_valid) got = 1'b1;
      else @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_total++; if ({alu_pwr_en, iso_en, alu_start, rsp_valid, cmd_ready} !== 5'b01001)
      $display("FAIL reset_ctrl: got %b expected 01001", {alu_pwr_en, iso_en, alu_start, rsp_valid, cmd_ready}); else n_pass++;
    n_total++; if ({alu_a, alu_b, alu_opcode, rsp_data, rsp_op, rsp_err} !== '0)
      $display("FAIL reset_data: got a=%0d b=%0d op=%0d rd=%0d ro=%0d re=%0b expected all 0", alu_a, alu_b, alu_opcode, rsp_data, rsp_op, rsp_err); else n_pass++;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    n_total++; if ({alu_pwr_en, iso_en} !== 2'b01)
      $display("FAIL off_no_traffic: got pwr/iso=%b expected 01", {alu_pwr_en, iso_en}); else n_pass++;
  endtask

  task automatic test_add();
    bit got;
    int starts;
    int iso_cyc = 0;
    cmd_a = 16'd3; cmd_b = 16'd5; cmd_op = OP_ADD; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    n_total++; if ({alu_pwr_en, iso_en} !== 2'b11)
      $display("FAIL add_pwr_rise: got pwr/iso=%b expected 11", {alu_pwr_en, iso_en}); else n_pass++;
    for (int t = 0; t < 20 && iso_en; t++) begin
      iso_cyc++;
      @(negedge clk);
    end
    n_total++; if (iso_cyc != 4)
      $display("FAIL add_iso_release: got %0d cycles isolated expected 4", iso_cyc); else n_pass++;
    wait_rsp(40, got, starts);
    n_total++; if (!got || starts != 1)
      $display("FAIL add_rsp: got rsp=%0b starts=%0d expected rsp=1 starts=1", got, starts); else n_pass++;
    n_total++; if ({rsp_data, rsp_op, rsp_err} !== {16'd8, OP_ADD, 1'b0})
      $display("FAIL add_data: got data=%0d op=%0d err=%0b expected 8 0 0", rsp_data, rsp_op, rsp_err); else n_pass++;
    repeat (3) @(negedge clk);
    n_total++; if (!rsp_valid || rsp_data !== 16'd8)
      $display("FAIL add_hold: got valid=%0b data=%0d expected 1 8", rsp_valid, rsp_data); else n_pass++;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    n_total++; if (rsp_valid !== 1'b0)
      $display("FAIL add_handshake: got valid=%0b expected 0", rsp_valid); else n_pass++;
  endtask

  task automatic test_mul();
    bit got = 1'b0;
    int busy_cyc = 0;
    int unstable = 0;
    cmd_a = 16'd300; cmd_b = 16'd7; cmd_op = OP_MUL; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int t = 0; t < 60 && !got; t++) begin
      if (alu_busy) begin
        busy_cyc++;
        if (alu_a !== 16'd300 || alu_b !== 16'd7 || alu_opcode !== OP_MUL) unstable++;
      end
      if (rsp_valid) got = 1'b1;
      else @(negedge clk);
    end
    n_total++; if (!got || busy_cyc != 5)
      $display("FAIL mul_busy: got rsp=%0b busy=%0d expected rsp=1 busy=5", got, busy_cyc); else n_pass++;
    n_total++; if (unstable != 0)
      $display("FAIL mul_operand_stable: got %0d unstable cycles expected 0", unstable); else n_pass++;
    n_total++; if ({rsp_data, rsp_op} !== {16'd2100, OP_MUL})
      $display("FAIL mul_data: got data=%0d op=%0d expected 2100 8", rsp_data, rsp_op); else n_pass++;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_fifo_full();
    logic [15:0] exp_sub [5] = '{16'd999, 16'd1098, 16'd1197, 16'd1296, 16'd1395};
    bit ok;
    int n_rsp = 0;
    rsp_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      push_cmd(16'(1000 + i * 100), 16'(i + 1), OP_SUB, ok);
      n_total++; if (ok !== (i < 5))
        $display("FAIL full_accept_%0d: got accepted=%0b expected %0b", i, ok, (i < 5)); else n_pass++;
    end
    n_total++; if (cmd_ready !== 1'b0)
      $display("FAIL full_ready: got cmd_ready=%0b expected 0", cmd_ready); else n_pass++;
    rsp_ready = 1'b1;
    for (int t = 0; t < 200 && n_rsp < 5; t++) begin
      if (rsp_valid) begin
        n_total++; if ({rsp_data, rsp_op} !== {exp_sub[n_rsp], OP_SUB})
          $display("FAIL full_rsp_%0d: got data=%0d op=%0d expected %0d 1", n_rsp, rsp_data, rsp_op, exp_sub[n_rsp]); else n_pass++;
        n_rsp++;
      end
      if (n_rsp < 5) @(negedge clk);
    end
    n_total++; if (n_rsp != 5)
      $display("FAIL full_rsp_count: got %0d expected 5", n_rsp); else n_pass++;
  endtask

  // Entered at the negedge before the final handshake of test_fifo_full.
  task automatic test_power_down();
    int t_iso = -1;
    int iso_cyc = 0;
    int starts;
    bit got;
    for (int t = 0; t < 40 && t_iso < 0; t++) begin
      @(negedge clk);
      rsp_ready = 1'b0;
      if (iso_en) t_iso = t;
    end
    n_total++; if (t_iso != 16 || alu_pwr_en !== 1'b1)
      $display("FAIL pd_iso: got iso after %0d idle cycles pwr=%0b expected 16 1", t_iso, alu_pwr_en); else n_pass++;
    @(negedge clk);
    n_total++; if ({alu_pwr_en, iso_en} !== 2'b01)
      $display("FAIL pd_off: got pwr/iso=%b expected 01", {alu_pwr_en, iso_en}); else n_pass++;
    cmd_a = 16'hF0F0; cmd_b = 16'h0FF0; cmd_op = OP_XOR; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    n_total++; if ({alu_pwr_en, iso_en} !== 2'b11)
      $display("FAIL pu_again_rise: got pwr/iso=%b expected 11", {alu_pwr_en, iso_en}); else n_pass++;
    for (int t = 0; t < 20 && iso_en; t++) begin
      iso_cyc++;
      @(negedge clk);
    end
    n_total++; if (iso_cyc != 4)
      $display("FAIL pu_again_iso: got %0d cycles isolated expected 4", iso_cyc); else n_pass++;
    wait_rsp(40, got, starts);
    n_total++; if (!got || rsp_data !== 16'hFF00)
      $display("FAIL pu_again_data: got rsp=%0b data=%0h expected 1 ff00", got, rsp_data); else n_pass++;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_div_err();
    logic [15:0] va   [3] = '{16'd100, 16'd100, 16'd5};
    logic [15:0] vb   [3] = '{16'd0, 16'd7, 16'd6};
    logic [3:0]  vop  [3] = '{OP_DIV, OP_DIV, 4'hC};
    logic [15:0] vexp [3] = '{16'd0, 16'd14, 16'd0};
    logic        verr [3] = '{ERR_EN, 1'b0, ERR_EN};
    bit ok, got, fwd_ok;
    for (int i = 0; i < 3; i++) begin
      push_cmd(va[i], vb[i], vop[i], ok);
      got = 1'b0;
      fwd_ok = 1'b0;
      for (int t = 0; t < 60 && !got; t++) begin
        if (alu_start) fwd_ok = (alu_a === va[i]) && (alu_b === vb[i]) && (alu_opcode === vop[i]);
        if (rsp_valid) got = 1'b1;
        else @(negedge clk);
      end
      n_total++; if (!ok || !got || !fwd_ok)
        $display("FAIL div_fwd_%0d: got acc=%0b rsp=%0b fwd=%0b expected 1 1 1", i, ok, got, fwd_ok); else n_pass++;
      n_total++; if ({rsp_data, rsp_op, rsp_err} !== {vexp[i], vop[i], verr[i]})
        $display("FAIL div_rsp_%0d: got data=%0d op=%0d err=%0b expected %0d %0d %0b", i, rsp_data, rsp_op, rsp_err, vexp[i], vop[i], verr[i]); else n_pass++;
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
    end
  endtask

  task automatic test_reset_mid();
    bit ok0, ok1;
    int leaks = 0;
    push_cmd(16'd1000, 16'd3, OP_DIV, ok0);
    push_cmd(16'd7, 16'd8, OP_ADD, ok1);
    for (int t = 0; t < 30 && !alu_busy; t++) @(negedge clk);
    n_total++; if (!ok0 || !ok1 || !alu_busy)
      $display("FAIL rstmid_setup: got acc=%0b%0b busy=%0b expected 11 1", ok0, ok1, alu_busy); else n_pass++;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_total++; if ({alu_pwr_en, iso_en, alu_start, rsp_valid, cmd_ready} !== 5'b01001 || {alu_a, alu_b, alu_opcode} !== '0)
      $display("FAIL rstmid_async: got ctrl=%b a=%0d b=%0d op=%0d expected 01001 0 0 0", {alu_pwr_en, iso_en, alu_start, rsp_valid, cmd_ready}, alu_a, alu_b, alu_opcode); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      if (rsp_valid || alu_pwr_en || alu_start) leaks++;
    end
    n_total++; if (leaks != 0)
      $display("FAIL rstmid_discard: got %0d cycles of activity expected 0", leaks); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_add();
    test_mul();
    test_fifo_full();
    test_power_down();
    test_div_err();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected bench completion");
    $fatal(1, "watchdog");
  end

endmodule
